// File: rtl/accel_ctrl_pkg.sv
// Shared encodings for the accelerator command driver: op codes, register
// indices, error codes and the sequencing FSM states.
package accel_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_ADD    = 3'b000,
      OP_SUB    = 3'b001,
      OP_MOD    = 3'b010,
      OP_RSETUP = 3'b011,
      OP_MULT   = 3'b100,
      OP_EXP    = 3'b101,
      OP_RSV6   = 3'b110,
      OP_RSV7   = 3'b111
   } op_e;

   localparam logic [2:0] REG_A      = 3'd0;
   localparam logic [2:0] REG_B      = 3'd1;
   localparam logic [2:0] REG_MOD    = 3'd2;
   localparam logic [2:0] REG_CTRL   = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;
   localparam logic [2:0] REG_RESULT = 3'd5;

   localparam logic [1:0] ERR_TIMEOUT  = 2'b00;
   localparam logic [1:0] ERR_BAD_OP   = 2'b01;
   localparam logic [1:0] ERR_EVEN_MOD = 2'b10;
   localparam logic [1:0] ERR_NO_R     = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_SETTLE = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // Ops that take more than one accelerator cycle and raise `finished`.
   function automatic logic is_seq_op(input logic [2:0] op);
      return (op == OP_MOD) || (op == OP_RSETUP) || (op == OP_EXP);
   endfunction

endpackage

// File: rtl/accel_cmd_driver.sv
// CPU-side command driver: bus-mapped operand/command/status/result registers
// that sequence one accelerator operation at a time and report its outcome.
module accel_cmd_driver
   import accel_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int MIN_WAIT       = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic                  re,
   input  logic [2:0]            addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic                  irq,
   output logic [DATA_WIDTH-1:0] acc_a,
   output logic [DATA_WIDTH-1:0] acc_b,
   output logic [DATA_WIDTH-1:0] acc_modulant,
   output logic [2:0]            acc_control,
   output logic                  acc_start,
   input  logic [DATA_WIDTH-1:0] acc_result,
   input  logic                  acc_finished
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   // Bus contract: we/re are single-cycle strobes with no back-pressure.
   // Writes land at the sampling edge; rdata holds the addressed value from
   // the cycle re was high and is valid the following cycle.
   state_e                state, state_nx;
   logic [DATA_WIDTH-1:0] a_q, b_q, mod_q, result_q;
   logic [2:0]            op_q, go_op;
   logic [1:0]            err_code_q, pre_code;
   logic                  irq_en_q, done_q, error_q, r_valid_q, wr_busy_q;
   logic [CNT_W-1:0]      cnt;
   logic                  busy, bus_wr, go_req, pre_err, stat_rd, wr_drop;
   logic                  load_result, time_out, set_done, set_err;
   logic [31:0]           status_word;
   logic                  unused_wdata;

   assign busy         = (state != ST_IDLE);
   assign bus_wr       = we && !busy;
   assign go_op        = wdata[2:0];
   assign go_req       = bus_wr && (addr == REG_CTRL) && wdata[8];
   assign stat_rd      = re && (addr == REG_STATUS);
   assign wr_drop      = we && busy && (addr <= REG_CTRL);
   assign set_err      = time_out || (go_req && pre_err);
   assign set_done     = load_result || set_err;
   assign unused_wdata = ^wdata;

   // Precondition checks, in priority order.
   always_comb begin
      pre_err  = 1'b0;
      pre_code = ERR_TIMEOUT;
      if (go_op == OP_RSV6 || go_op == OP_RSV7) begin
         pre_err  = 1'b1;
         pre_code = ERR_BAD_OP;
      end else if (go_op == OP_MULT || go_op == OP_EXP) begin
         if (!mod_q[0]) begin
            pre_err  = 1'b1;
            pre_code = ERR_EVEN_MOD;
         end else if (!r_valid_q) begin
            pre_err  = 1'b1;
            pre_code = ERR_NO_R;
         end
      end
   end

   always_comb begin
      state_nx    = state;
      load_result = 1'b0;
      time_out    = 1'b0;
      case (state)
         ST_IDLE:   if (go_req && !pre_err) state_nx = ST_LAUNCH;
         ST_LAUNCH: state_nx = is_seq_op(op_q) ? ST_WAIT : ST_SETTLE;
         ST_SETTLE: begin
            load_result = 1'b1;
            state_nx    = ST_DONE;
         end
         ST_WAIT: begin
            // A `finished` left high from a previous op is masked by MIN_WAIT.
            if (cnt >= CNT_W'(MIN_WAIT) && acc_finished) begin
               load_result = 1'b1;
               state_nx    = ST_DONE;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               time_out = 1'b1;
               state_nx = ST_DONE;
            end
         end
         ST_DONE:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q        <= '0;
         b_q        <= '0;
         mod_q      <= '0;
         result_q   <= '0;
         op_q       <= '0;
         irq_en_q   <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= ERR_TIMEOUT;
         r_valid_q  <= 1'b0;
         wr_busy_q  <= 1'b0;
         cnt        <= '0;
      end else begin
         if (bus_wr) begin
            case (addr)
               REG_A:    a_q      <= wdata[DATA_WIDTH-1:0];
               REG_B:    b_q      <= wdata[DATA_WIDTH-1:0];
               REG_MOD:  mod_q    <= wdata[DATA_WIDTH-1:0];
               REG_CTRL: irq_en_q <= wdata[3];
               default:  ;
            endcase
         end
         if (go_req && !pre_err) op_q <= go_op;
         cnt <= (state == ST_WAIT) ? cnt + CNT_W'(1) : '0;
         if (load_result) result_q <= acc_result;

         // Flag sets win over the read-to-clear of STATUS in the same cycle.
         if (set_done)     done_q <= 1'b1;
         else if (stat_rd) done_q <= 1'b0;
         if (set_err) begin
            error_q    <= 1'b1;
            err_code_q <= time_out ? ERR_TIMEOUT : pre_code;
         end else if (stat_rd) begin
            error_q <= 1'b0;
         end
         if (wr_drop)      wr_busy_q <= 1'b1;
         else if (stat_rd) wr_busy_q <= 1'b0;

         if (bus_wr && addr == REG_MOD)
            r_valid_q <= 1'b0;
         else if (load_result && state == ST_WAIT && op_q == OP_RSETUP)
            r_valid_q <= 1'b1;
      end
   end

   assign status_word = {24'd0, wr_busy_q, r_valid_q, err_code_q, 1'b0,
                         error_q, done_q, busy};

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (re) begin
         case (addr)
            REG_A:      rdata <= 32'(a_q);
            REG_B:      rdata <= 32'(b_q);
            REG_MOD:    rdata <= 32'(mod_q);
            REG_STATUS: rdata <= status_word;
            REG_RESULT: rdata <= 32'(result_q);
            default:    rdata <= '0;
         endcase
      end
   end

   assign acc_a        = a_q;
   assign acc_b        = b_q;
   assign acc_modulant = mod_q;
   assign acc_control  = op_q;
   assign acc_start    = (state == ST_LAUNCH);
   assign irq          = done_q && irq_en_q;

endmodule

// File: tb/tb_accel_cmd_driver.sv
// Bench for accel_cmd_driver: a table of single operations followed by
// hand-written multi-cycle sequences, against a small accelerator stub.
module tb_accel_cmd_driver;
   import accel_ctrl_pkg::*;

   localparam int DW = 8;
   localparam int MW = 2;
   localparam int TO = 32;

   logic          clk = 1'b0;
   logic          reset, we, re;
   logic [2:0]    addr;
   logic [31:0]   wdata, rdata;
   logic          irq;
   logic [DW-1:0] acc_a, acc_b, acc_modulant, acc_result;
   logic [2:0]    acc_control;
   logic          acc_start, acc_finished;

   always #5 clk = ~clk;

   accel_cmd_driver #(.DATA_WIDTH(DW), .MIN_WAIT(MW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr), .wdata(wdata),
      .rdata(rdata), .irq(irq), .acc_a(acc_a), .acc_b(acc_b),
      .acc_modulant(acc_modulant), .acc_control(acc_control),
      .acc_start(acc_start), .acc_result(acc_result), .acc_finished(acc_finished)
   );

   function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] m);
      int unsigned ai, bi, mi, r;
      ai = 32'(a);
      bi = 32'(b);
      mi = 32'(m);
      r  = 0;
      if (mi == 0) return 8'h00;
      case (op)
         3'b000: r = (ai + bi) % mi;
         3'b001: r = ((ai % mi) + mi - (bi % mi)) % mi;
         3'b010: r = ai % mi;
         3'b011: r = 256 % mi;
         3'b100: r = (ai * bi) % mi;
         3'b101: begin
            r = 1 % mi;
            for (int i = 0; i < int'(bi); i++) r = (r * ai) % mi;
         end
         default: r = 0;
      endcase
      return r[7:0];
   endfunction

   // Stub: since_start counts cycles after the start pulse (0 in the first
   // cycle after it); finished rises once since_start reaches fin_at.
   int start_cnt   = 0;
   int since_start = 1000;
   int fin_at      = -1;
   bit stale_en    = 1'b0;
   always @(posedge clk) begin
      if (acc_start) begin
         since_start <= 0;
         start_cnt   <= start_cnt + 1;
      end else if (since_start < 1000) begin
         since_start <= since_start + 1;
      end
   end
   assign acc_finished = (stale_en && since_start == 0) ||
                         (fin_at >= 0 && since_start >= fin_at && since_start < 1000);
   assign acc_result   = (stale_en && since_start == 0) ? 8'hEE :
                         model(acc_control, acc_a, acc_b, acc_modulant);

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      we = 1'b0; wdata = '0;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string nm);
      re = 1'b1; addr = a;
      exp_q.push_back(exp);
      @(negedge clk);
      re = 1'b0;
      check(nm, rdata, exp_q.pop_front());
   endtask

   task automatic wait_irq(output int lat);
      lat = 1;
      while (irq !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   function automatic logic [31:0] ctrl_word(input logic [2:0] op);
      return {23'd0, 1'b1, 4'b0000, 1'b1, op};
   endfunction

   function automatic logic [31:0] stat(input bit wb, input bit rv, input logic [1:0] code,
                                        input bit err, input bit dn, input bit bz);
      return {24'd0, wb, rv, code, 1'b0, err, dn, bz};
   endfunction

   typedef struct {
      logic [2:0] op;
      logic [7:0] a, b, m;
      bit         wm;
      int         fin;
      bit         err;
      logic [1:0] code;
      logic [7:0] res;
      int         lat;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs[NV];

   logic [7:0] exp_res = 8'h00;
   bit         exp_rv  = 1'b0;
   logic [1:0] exp_code = 2'b00;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, s0;
      vec_t v;
      reset = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;

      //               op      a      b      m     wm  fin err code   res   lat
      vecs[0]  = '{3'b000, 8'd9,   8'd7, 8'd13, 1'b1, -1, 1'b0, 2'b00, 8'd3,  3};
      vecs[1]  = '{3'b100, 8'd9,   8'd7, 8'd13, 1'b0, -1, 1'b1, 2'b11, 8'd0,  1};
      vecs[2]  = '{3'b001, 8'd5,   8'd9, 8'd13, 1'b0, -1, 1'b0, 2'b00, 8'd9,  3};
      vecs[3]  = '{3'b011, 8'd9,   8'd7, 8'd15, 1'b1,  3, 1'b0, 2'b00, 8'd1,  6};
      vecs[4]  = '{3'b100, 8'd8,   8'd7, 8'd15, 1'b0, -1, 1'b0, 2'b00, 8'd11, 3};
      vecs[5]  = '{3'b101, 8'd7,   8'd2, 8'd15, 1'b0,  0, 1'b0, 2'b00, 8'd4,  5};
      vecs[6]  = '{3'b010, 8'd200, 8'd7, 8'd15, 1'b1,  4, 1'b0, 2'b00, 8'd5,  7};
      vecs[7]  = '{3'b100, 8'd8,   8'd7, 8'd15, 1'b0, -1, 1'b1, 2'b11, 8'd0,  1};
      vecs[8]  = '{3'b101, 8'd7,   8'd2, 8'd12, 1'b1, -1, 1'b1, 2'b10, 8'd0,  1};
      vecs[9]  = '{3'b110, 8'd7,   8'd2, 8'd12, 1'b0, -1, 1'b1, 2'b01, 8'd0,  1};
      vecs[10] = '{3'b111, 8'd7,   8'd2, 8'd12, 1'b0, -1, 1'b1, 2'b01, 8'd0,  1};

      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("rst_acc_start", 32'(acc_start), 0);
      check("rst_acc_control", 32'(acc_control), 0);
      check("rst_acc_a", 32'(acc_a), 0);
      check("rst_rdata", rdata, 0);
      check("rst_irq", 32'(irq), 0);
      bus_read(REG_STATUS, 32'h0, "rst_status");
      bus_read(REG_RESULT, 32'h0, "rst_result");

      for (int i = 0; i < NV; i++) begin
         v = vecs[i];
         bus_write(REG_A, 32'(v.a));
         bus_write(REG_B, 32'(v.b));
         if (v.wm) begin
            bus_write(REG_MOD, 32'(v.m));
            exp_rv = 1'b0;
         end
         check($sformatf("v%0d_acc_a", i), 32'(acc_a), 32'(v.a));
         fin_at = v.fin;
         s0 = start_cnt;
         bus_write(REG_CTRL, ctrl_word(v.op));
         check($sformatf("v%0d_start_c1", i), 32'(acc_start), 32'(!v.err));
         wait_irq(lat);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(v.lat));
         @(negedge clk);
         if (v.err) begin
            exp_code = v.code;
         end else begin
            exp_res = v.res;
            if (v.op == 3'b011) exp_rv = 1'b1;
            check($sformatf("v%0d_acc_control", i), 32'(acc_control), 32'(v.op));
         end
         check($sformatf("v%0d_start_count", i), 32'(start_cnt - s0), 32'(!v.err));
         bus_read(REG_RESULT, 32'(exp_res), $sformatf("v%0d_result", i));
         bus_read(REG_STATUS, stat(1'b0, exp_rv, exp_code, v.err, 1'b1, 1'b0),
                  $sformatf("v%0d_status", i));
      end

      // Stale finished in the first WAIT cycle, real one 20 cycles after go.
      bus_write(REG_A, 32'd100);
      bus_write(REG_MOD, 32'd13);
      stale_en = 1'b1;
      fin_at   = 18;
      bus_write(REG_CTRL, ctrl_word(3'b010));
      wait_irq(lat);
      check("stale_latency", 32'(lat), 32'd21);
      @(negedge clk);
      stale_en = 1'b0;
      exp_res  = 8'd9;
      bus_read(REG_RESULT, 32'(exp_res), "stale_result");
      bus_read(REG_STATUS, stat(1'b0, 1'b0, exp_code, 1'b0, 1'b1, 1'b0), "stale_status");

      // Timeout on R setup, then a good R setup.
      bus_write(REG_MOD, 32'd15);
      fin_at = -1;
      s0 = start_cnt;
      bus_write(REG_CTRL, ctrl_word(3'b011));
      wait_irq(lat);
      check("timeout_window", 32'(lat >= TO + 2 && lat <= TO + 4), 32'd1);
      @(negedge clk);
      exp_code = 2'b00;
      check("timeout_starts", 32'(start_cnt - s0), 32'd1);
      bus_read(REG_RESULT, 32'(exp_res), "timeout_result_kept");
      bus_read(REG_STATUS, stat(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0), "timeout_status");
      fin_at = 2;
      bus_write(REG_CTRL, ctrl_word(3'b011));
      wait_irq(lat);
      @(negedge clk);
      exp_res = 8'd1;
      exp_rv  = 1'b1;
      bus_read(REG_RESULT, 32'(exp_res), "rsetup_result");
      bus_read(REG_STATUS, stat(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0), "rsetup_status");

      // Writes while busy are dropped and flagged.
      fin_at = 10;
      s0 = start_cnt;
      bus_write(REG_CTRL, ctrl_word(3'b010));
      repeat (3) @(negedge clk);
      bus_write(REG_A, 32'h55);
      check("busy_acc_a_kept", 32'(acc_a), 32'd100);
      bus_write(REG_MOD, 32'd14);
      bus_write(REG_CTRL, ctrl_word(3'b000));
      wait_irq(lat);
      @(negedge clk);
      check("busy_start_count", 32'(start_cnt - s0), 32'd1);
      check("busy_acc_mod_kept", 32'(acc_modulant), 32'd15);
      exp_res = 8'd10;
      bus_read(REG_RESULT, 32'(exp_res), "busy_result");
      bus_read(REG_STATUS, stat(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0), "busy_status");

      // STATUS read in the cycle that sets done: old value, done survives.
      bus_write(REG_B, 32'd7);
      bus_write(REG_CTRL, ctrl_word(3'b000));
      @(negedge clk);
      bus_read(REG_STATUS, stat(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1), "race_status_old");
      check("race_irq_kept", 32'(irq), 32'd1);
      @(negedge clk);
      bus_read(REG_STATUS, stat(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0), "race_status_done");
      bus_read(REG_STATUS, stat(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), "race_status_clr");
      check("race_irq_clr", 32'(irq), 32'd0);
      bus_read(REG_RESULT, 32'd2, "race_result");

      // Write and read of A in the same cycle.
      we = 1'b1; re = 1'b1; addr = REG_A; wdata = 32'h21;
      exp_q.push_back(32'd100);
      @(negedge clk);
      we = 1'b0; re = 1'b0; wdata = '0;
      check("wr_rd_old_value", rdata, exp_q.pop_front());
      check("wr_rd_acc_a", 32'(acc_a), 32'h21);

      // Reset in the middle of WAIT.
      fin_at = -1;
      bus_write(REG_CTRL, ctrl_word(3'b011));
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_acc_start", 32'(acc_start), 0);
      check("mid_rst_acc_control", 32'(acc_control), 0);
      check("mid_rst_operands", {8'd0, acc_a, acc_b, acc_modulant}, 0);
      check("mid_rst_irq", 32'(irq), 0);
      check("mid_rst_rdata", rdata, 0);
      s0 = start_cnt;
      repeat (5) @(negedge clk);
      check("mid_rst_no_start", 32'(start_cnt - s0), 0);
      bus_read(REG_STATUS, 32'h0, "mid_rst_status");
      bus_read(REG_RESULT, 32'h0, "mid_rst_result");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
